fifo_rd_ctrl: RTL
=================

Name: fifo_rd_ctrl

Overview:
Read-side controller for the synchronous `fifo` block. It pops words from the FIFO's read port, which has 1-cycle read latency. It re-times them into a small skid buffer and presents them on a valid/ready stream to a downstream consumer. It never reads an empty FIFO, preserves word order, and sustains one word per cycle when the consumer is always ready.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- BUF_DEPTH, 2, skid buffer entries (min 2).
- CNT_WIDTH, 16, width of optional beat counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_  in  1  reset.
- enable  in  1  permission to issue new FIFO reads.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid the cycle after a sampled fifo_rd_en.
- fifo_rd_en  out  1  FIFO pop request.
- m_valid  out  1  stream data valid.
- m_ready  in  1  consumer accepts.
- m_data  out  DATA_WIDTH  stream data.
- busy  out  1  state != IDLE.
- rd_count  out  CNT_WIDTH  accepted-beat counter (see Optional Feature).

Interface (already decided):
- One clock, clk.
- Reset rst_ is asynchronous and active-low.

Behaviour:
- Reset (rst_=0, asynchronous):
  - state=IDLE; buffer occupancy occ=0; inflight=0.
  - fifo_rd_en=0, m_valid=0, m_data=0, busy=0, rd_count=0.
- Reset mid-operation discards buffered and in-flight words. Any FIFO read already issued is lost from the controller's view.
- State machine:
  - IDLE: no reads. enable=1 → RUN next cycle.
  - RUN: issue reads per the rule below. enable=0 → DRAIN.
  - DRAIN: no new reads; deliver remaining words. Go to IDLE when occ==0 and inflight==0 (and no arrival this cycle). enable=1 → RUN.
- Read issue rule:
  - fifo_rd_en = (state==RUN) && !fifo_empty && ((occ+inflight < BUF_DEPTH) || (m_valid && m_ready)).
  - This is combinational on m_ready and fifo_empty.
- inflight is a register: set to 1 the cycle after fifo_rd_en=1, else 0.
- When inflight=1, fifo_dout is written to the buffer tail that cycle.
- Stream output:
  - m_valid = (occ != 0).
  - m_data = buffer head; held stable while m_valid && !m_ready.
  - A beat transfers on posedge with m_valid && m_ready; head advances.
- Simultaneous arrival and pop in the same cycle: occ unchanged, FIFO order kept.
- Buffer is a circular array with head/tail pointers wrapping at BUF_DEPTH. The issue rule guarantees occ never exceeds BUF_DEPTH; overflow is a design error (assert).
- Latency: fifo_rd_en at cycle N → word at buffer at N+1 → m_valid high from N+2 (registered buffer, no bypass).
- Throughput: one beat per cycle sustained with m_ready held 1 and FIFO non-empty.
- fifo_empty rising while inflight=1: in-flight word is still captured; no further reads issued.
- enable drop: in-flight and buffered words are still delivered.

Optional Feature:
Macro: FIFO_RD_CNT_EN.
- Defined: rd_count increments by 1 on every accepted beat (m_valid && m_ready). It wraps modulo 2^CNT_WIDTH and clears only on reset.
- Undefined: rd_count is driven constant 0; no counter flops are instantiated. The port stays present in both builds.

Test Plan:
1. Reset then steady stream:
   - Stimulus: FIFO (depth 16) preloaded with 0..15, enable=1, m_ready=1.
   - Response: m_data 0..15 on 16 consecutive cycles, first m_valid 2 cycles after first fifo_rd_en, no gaps.
   - With FIFO_RD_CNT_EN: rd_count=16.
2. Back-pressure:
   - Stimulus: FIFO holds 0..7, m_ready=0 for 10 cycles, then 1.
   - Response: at most 2 fifo_rd_en pulses during the stall; m_data holds 0 while stalled; then 0..7 in order with none lost or duplicated.
3. Empty FIFO:
   - Stimulus: enable=1, fifo_empty=1 for 20 cycles; then write 0xA5.
   - Response: fifo_rd_en never asserted while empty; 0xA5 is delivered once.
4. Enable drop:
   - Stimulus: streaming 0..15; enable deasserted after beat 4 is accepted.
   - Response: buffered and in-flight words (≤2) still delivered in order; no further reads; DRAIN→IDLE; busy falls to 0.
5. Async reset mid-stream:
   - Stimulus: rst_=0 asserted between clock edges with occ=2.
   - Response: m_valid, fifo_rd_en, busy and rd_count go to 0 immediately, without waiting for a clock edge.
6. Counter wrap:
   - Stimulus: FIFO_RD_CNT_EN defined, CNT_WIDTH=4, 17 beats.
   - Response: rd_count=1.
   - Without the macro: rd_count stays 0.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: pops a 1-cycle-latency FIFO into a skid buffer feeding a valid/ready stream; FIFO_RD_CNT_EN adds an accepted-beat counter.
// rd_en -> m_valid is 2 cycles; m_ready low holds the head and throttles reads once buffered + in-flight words fill the buffer.
module fifo_rd_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int BUF_DEPTH  = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  rd_count
);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int OW = $clog2(BUF_DEPTH + 1);
   localparam logic [OW-1:0] DEPTH_O = OW'(BUF_DEPTH);
   localparam logic [PW-1:0] LAST_P  = PW'(BUF_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
   logic [PW-1:0]         head, tail;
   logic [OW-1:0]         occ;
   logic [OW:0]           fill;
   logic                  inflight;
   logic                  push, pop;

   assign push     = inflight;
   assign pop      = m_valid && m_ready;
   assign fill     = {1'b0, occ} + {{OW{1'b0}}, inflight};
   assign m_valid  = (occ != '0);
   assign m_data   = buf_mem[head];
   assign busy     = (state != IDLE);

   // A pop this cycle frees the slot the new read lands in, so m_ready feeds rd_en directly.
   assign fifo_rd_en = (state == RUN) && !fifo_empty && ((fill < {1'b0, DEPTH_O}) || pop);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = RUN;
         RUN:     if (!enable) state_nxt = DRAIN;
         DRAIN: begin
            if (enable)                         state_nxt = RUN;
            else if (occ == '0 && !inflight)    state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state    <= IDLE;
         inflight <= 1'b0;
         occ      <= '0;
         head     <= '0;
         tail     <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= fifo_rd_en;
         if (push) begin
            buf_mem[tail] <= fifo_dout;
            tail          <= (tail == LAST_P) ? '0 : tail + 1'b1;
         end
         if (pop) head <= (head == LAST_P) ? '0 : head + 1'b1;
         if (push && !pop)      occ <= occ + 1'b1;
         else if (!push && pop) occ <= occ - 1'b1;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_)
      !(push && !pop && occ == DEPTH_O));

`ifdef FIFO_RD_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)    cnt_q <= '0;
      else if (pop) cnt_q <= cnt_q + 1'b1;
   end

   assign rd_count = cnt_q;
`else
   assign rd_count = '0;
`endif

endmodule
